// File: rtl/fft_twiddle_cmult.sv
// Pipelined complex twiddle multiplier for one FFT stage lane.
// Sample index counter drives the twiddle ROM address; the ROM answers one
// cycle later and the product is emitted at full precision three cycles after
// the sample is accepted.
module fft_twiddle_cmult #(
  parameter int unsigned N      = 128,
  parameter int unsigned STAGE  = 0,
  parameter int unsigned NB_D   = 15,
  parameter int unsigned NBF_D  = 12,
  parameter int unsigned NB_TW  = 12,
  parameter int unsigned NBF_TW = 10,
  parameter int unsigned NB_OUT = NB_D + NB_TW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic                     i_sop,
  input  logic [NB_D-1:0]          i_re,
  input  logic [NB_D-1:0]          i_im,
  output logic [$clog2(N)-2:0]     o_tw_addr,
  input  logic [NB_TW-1:0]         i_tw_re,
  input  logic [NB_TW-1:0]         i_tw_im,
  output logic                     o_valid,
  output logic                     o_sop,
  output logic signed [NB_OUT-1:0] o_re,
  output logic signed [NB_OUT-1:0] o_im
);

  localparam int unsigned Log2N = $clog2(N);
  localparam int unsigned Aw    = Log2N - 1;
  localparam int unsigned Np    = NB_D + NB_TW;
  // Keeps idx mod 2^(Aw-STAGE); the shift by STAGE then yields the stride.
  localparam logic [Aw-1:0] AddrMask = Aw'((1 << (Aw - STAGE)) - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (STAGE > Log2N - 2) begin : g_bad_stage
    $error("STAGE out of range");
  end
  if (NB_OUT < Np + 1) begin : g_bad_out
    $error("NB_OUT too narrow for full-precision result");
  end
  if (NBF_D >= NB_D || NBF_TW >= NB_TW) begin : g_bad_frac
    $error("fractional bits must leave room for the sign bit");
  end

  logic [Log2N-1:0] cnt_q, cnt_d, idx;

  logic                    v1_q, sop1_q;
  logic signed [NB_D-1:0]  x_re_q, x_im_q;

  logic                    v2_q, sop2_q;
  logic signed [Np-1:0]    rr_q, ii_q, ri_q, ir_q;
  logic signed [Np-1:0]    rr_d, ii_d, ri_d, ir_d;

  logic signed [NB_OUT-1:0] re_d, im_d;

  // Effective index, twiddle address and next counter value.
  always_comb begin
    idx       = (i_valid && i_sop) ? '0 : cnt_q;
    o_tw_addr = (idx[Aw-1:0] & AddrMask) << STAGE;
    cnt_d     = i_valid ? idx + Log2N'(1) : cnt_q;
  end

  // Sample index counter.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Stage 1: capture the sample while the ROM fetches its twiddle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sop1_q <= 1'b0;
      x_re_q <= '0;
      x_im_q <= '0;
    end else begin
      v1_q   <= i_valid;
      sop1_q <= i_valid & i_sop;
      x_re_q <= i_re;
      x_im_q <= i_im;
    end
  end

  // Four partial products, operands sign-extended to the product width.
  always_comb begin
    rr_d = $signed({{NB_TW{x_re_q[NB_D-1]}}, x_re_q}) * $signed({{NB_D{i_tw_re[NB_TW-1]}}, i_tw_re});
    ii_d = $signed({{NB_TW{x_im_q[NB_D-1]}}, x_im_q}) * $signed({{NB_D{i_tw_im[NB_TW-1]}}, i_tw_im});
    ri_d = $signed({{NB_TW{x_re_q[NB_D-1]}}, x_re_q}) * $signed({{NB_D{i_tw_im[NB_TW-1]}}, i_tw_im});
    ir_d = $signed({{NB_TW{x_im_q[NB_D-1]}}, x_im_q}) * $signed({{NB_D{i_tw_re[NB_TW-1]}}, i_tw_re});
  end

  // Stage 2: register the products.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      sop2_q <= 1'b0;
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
    end else begin
      v2_q   <= v1_q;
      sop2_q <= sop1_q;
      rr_q   <= rr_d;
      ii_q   <= ii_d;
      ri_q   <= ri_d;
      ir_q   <= ir_d;
    end
  end

  // Combine in the wider output format so (-4)(-2)+(-4)(-2) cannot wrap.
  always_comb begin
    re_d = $signed({{(NB_OUT - Np){rr_q[Np-1]}}, rr_q}) -
           $signed({{(NB_OUT - Np){ii_q[Np-1]}}, ii_q});
    im_d = $signed({{(NB_OUT - Np){ri_q[Np-1]}}, ri_q}) +
           $signed({{(NB_OUT - Np){ir_q[Np-1]}}, ir_q});
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
    end else begin
      o_valid <= v2_q;
      o_sop   <= sop2_q;
      o_re    <= re_d;
      o_im    <= im_d;
    end
  end

endmodule

// File: tb/tb_fft_twiddle_cmult.sv
// Directed bench for fft_twiddle_cmult: a STAGE=0 and a STAGE=2 instance share
// stimulus; a behavioural ROM answers each address one cycle later.
module tb_fft_twiddle_cmult;

  logic clk = 1'b0;
  logic rst, i_valid, i_sop;
  logic [14:0] i_re, i_im;

  logic [5:0] addr0, addr2;
  logic signed [11:0] tw_re0, tw_im0, tw_re2, tw_im2;
  logic o_valid0, o_sop0, o_valid2, o_sop2;
  logic signed [27:0] o_re0, o_im0, o_re2, o_im2;

  logic signed [11:0] rom_re [64];
  logic signed [11:0] rom_im [64];

  int n_cmp = 0;
  int n_bad = 0;

  // Bench model state: index counter and a 3-deep expected pipeline per instance.
  logic [6:0] m_cnt;
  logic       m_v  [1:3];
  logic       m_s  [1:3];
  longint     m_re0[1:3], m_im0[1:3], m_re2[1:3], m_im2[1:3];

  always #5 clk = ~clk;

  fft_twiddle_cmult #(.N(128), .STAGE(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sop(i_sop), .i_re(i_re), .i_im(i_im),
    .o_tw_addr(addr0), .i_tw_re(tw_re0), .i_tw_im(tw_im0),
    .o_valid(o_valid0), .o_sop(o_sop0), .o_re(o_re0), .o_im(o_im0)
  );

  fft_twiddle_cmult #(.N(128), .STAGE(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sop(i_sop), .i_re(i_re), .i_im(i_im),
    .o_tw_addr(addr2), .i_tw_re(tw_re2), .i_tw_im(tw_im2),
    .o_valid(o_valid2), .o_sop(o_sop2), .o_re(o_re2), .o_im(o_im2)
  );

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) begin
    tw_re0 <= rom_re[addr0];
    tw_im0 <= rom_im[addr0];
    tw_re2 <= rom_re[addr2];
    tw_im2 <= rom_im[addr2];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint cre(input logic [14:0] re, input logic [14:0] im,
                                 input logic signed [11:0] tr, input logic signed [11:0] ti);
    return longint'($signed(re)) * longint'(tr) - longint'($signed(im)) * longint'(ti);
  endfunction

  function automatic longint cim(input logic [14:0] re, input logic [14:0] im,
                                 input logic signed [11:0] tr, input logic signed [11:0] ti);
    return longint'($signed(re)) * longint'(ti) + longint'($signed(im)) * longint'(tr);
  endfunction

  task automatic rom_default();
    for (int a = 0; a < 64; a++) begin
      rom_re[a] = 12'(a * 16 - 500);
      rom_im[a] = 12'(300 - a * 8);
    end
  endtask

  // One clock: drive at the falling edge, check the address, advance the model,
  // then check both instances' outputs at the next falling edge.
  task automatic cycle(input logic r, input logic v, input logic s,
                       input logic [14:0] re, input logic [14:0] im,
                       output logic [5:0] seen);
    logic [6:0] idx;
    logic [5:0] a0, a2;
    rst = r; i_valid = v; i_sop = s; i_re = re; i_im = im;
    #1;
    seen = addr0;
    idx  = (v && s) ? 7'd0 : m_cnt;
    a0   = idx[5:0];
    a2   = {idx[3:0], 2'b00};
    if (v && !r) begin
      chk("addr_stage0", longint'(addr0), longint'(a0));
      chk("addr_stage2", longint'(addr2), longint'(a2));
    end
    for (int k = 3; k > 1; k--) begin
      m_v[k] = m_v[k-1]; m_s[k] = m_s[k-1];
      m_re0[k] = m_re0[k-1]; m_im0[k] = m_im0[k-1];
      m_re2[k] = m_re2[k-1]; m_im2[k] = m_im2[k-1];
    end
    m_v[1]   = v;
    m_s[1]   = v && s;
    m_re0[1] = cre(re, im, rom_re[a0], rom_im[a0]);
    m_im0[1] = cim(re, im, rom_re[a0], rom_im[a0]);
    m_re2[1] = cre(re, im, rom_re[a2], rom_im[a2]);
    m_im2[1] = cim(re, im, rom_re[a2], rom_im[a2]);
    if (r) begin
      m_cnt = 7'd0;
      for (int k = 1; k <= 3; k++) begin m_v[k] = 1'b0; m_s[k] = 1'b0; end
    end else if (v) begin
      m_cnt = idx + 7'd1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("valid_stage0", longint'(o_valid0), longint'(m_v[3]));
    chk("valid_stage2", longint'(o_valid2), longint'(m_v[3]));
    chk("sop_stage0", longint'(o_sop0), longint'(m_s[3]));
    chk("sop_stage2", longint'(o_sop2), longint'(m_s[3]));
    if (m_v[3]) begin
      chk("re_stage0", longint'(o_re0), m_re0[3]);
      chk("im_stage0", longint'(o_im0), m_im0[3]);
      chk("re_stage2", longint'(o_re2), m_re2[3]);
      chk("im_stage2", longint'(o_im2), m_im2[3]);
    end
  endtask

  task automatic idle(input int n);
    logic [5:0] sn;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 15'd0, 15'd0, sn);
  endtask

  task automatic do_reset();
    logic [5:0] sn;
    cycle(1'b1, 1'b0, 1'b0, 15'd0, 15'd0, sn);
  endtask

  task automatic chk_zero_out(input string nm);
    chk({nm, "_valid"}, longint'(o_valid0), 0);
    chk({nm, "_sop"}, longint'(o_sop0), 0);
    chk({nm, "_re"}, longint'(o_re0), 0);
    chk({nm, "_im"}, longint'(o_im0), 0);
  endtask

  typedef struct {
    int                 pre;
    logic               sop;
    logic [14:0]        re;
    logic [14:0]        im;
    logic signed [11:0] twr;
    logic signed [11:0] twi;
    logic [5:0]         addr;
    longint             exp_re;
    longint             exp_im;
  } vec_t;

  vec_t vec[6];

  initial begin
    logic [5:0] sn;
    int nv;

    vec[0] = '{0,   1'b1, 15'h1000, 15'h0000,  12'sd1024,  12'sd0,    6'd0,  64'sh400000, 0};
    vec[1] = '{32,  1'b0, 15'h1000, 15'h0800,  12'sd0,    -12'sd1024, 6'd32, 64'sh200000, -64'sh400000};
    vec[2] = '{5,   1'b0, 15'h4000, 15'h4000, -12'sd2048, -12'sd2048, 6'd5,  0,           64'sh4000000};
    vec[3] = '{0,   1'b0, 15'h7fff, 15'h0001,  12'sd2047, -12'sd2048, 6'd0,  1,           4095};
    vec[4] = '{127, 1'b0, 15'h3fff, 15'h4000, -12'sd2048,  12'sd2047, 6'd63, -14336,      67090433};
    vec[5] = '{128, 1'b0, 15'h0100, 15'h7f00,  12'sd100,  -12'sd50,   6'd0,  12800,       -38400};

    rom_default();
    m_cnt = '0;
    for (int k = 1; k <= 3; k++) begin
      m_v[k] = 1'b0; m_s[k] = 1'b0;
      m_re0[k] = 0; m_im0[k] = 0; m_re2[k] = 0; m_im2[k] = 0;
    end
    rst = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_re = '0; i_im = '0;
    @(negedge clk);

    do_reset();
    chk_zero_out("reset");

    // Table vectors: reset, walk the counter to the wanted index, apply the sample.
    for (int n = 0; n < 6; n++) begin
      rom_re[vec[n].addr] = vec[n].twr;
      rom_im[vec[n].addr] = vec[n].twi;
      do_reset();
      for (int p = 0; p < vec[n].pre; p++)
        cycle(1'b0, 1'b1, p == 0, 15'($urandom), 15'($urandom), sn);
      cycle(1'b0, 1'b1, vec[n].sop, vec[n].re, vec[n].im, sn);
      chk($sformatf("vec%0d_addr", n), longint'(sn), longint'(vec[n].addr));
      idle(2);
      chk($sformatf("vec%0d_valid", n), longint'(o_valid0), 1);
      chk($sformatf("vec%0d_re", n), longint'(o_re0), vec[n].exp_re);
      chk($sformatf("vec%0d_im", n), longint'(o_im0), vec[n].exp_im);
      idle(1);
      rom_default();
    end

    // 130 valid samples with a bubble every third cycle; counter wraps 127 -> 0.
    do_reset();
    nv = 0;
    for (int i = 0; nv < 130; i++) begin
      if (i % 3 == 2) begin
        cycle(1'b0, 1'b0, 1'b0, 15'($urandom), 15'($urandom), sn);
      end else begin
        cycle(1'b0, 1'b1, nv == 0, 15'($urandom), 15'($urandom), sn);
        if (nv == 128) chk("wrap_addr", longint'(sn), 0);
        nv++;
      end
    end
    idle(3);

    // Mid-frame sop at index 50 restarts at 0; in-flight samples drain unchanged.
    do_reset();
    for (int p = 0; p < 50; p++)
      cycle(1'b0, 1'b1, p == 0, 15'($urandom), 15'($urandom), sn);
    cycle(1'b0, 1'b1, 1'b1, 15'($urandom), 15'($urandom), sn);
    chk("restart_addr", longint'(sn), 0);
    cycle(1'b0, 1'b1, 1'b0, 15'($urandom), 15'($urandom), sn);
    chk("restart_next_addr", longint'(sn), 1);
    cycle(1'b0, 1'b0, 1'b1, 15'($urandom), 15'($urandom), sn);
    chk("restart_sop_pulse", longint'(o_sop0), 1);
    idle(1);
    chk("restart_sop_single", longint'(o_sop0), 0);
    idle(2);

    // Reset with samples in flight drops them; next sample indexes from 0.
    do_reset();
    for (int p = 0; p < 5; p++)
      cycle(1'b0, 1'b1, p == 0, 15'($urandom), 15'($urandom), sn);
    do_reset();
    chk_zero_out("midrst");
    idle(3);
    chk("midrst_after_valid", longint'(o_valid0), 0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0123, 15'h7abc, sn);
    chk("midrst_first_addr", longint'(sn), 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
